sort_stream_adapter: RTL
========================

# sort_stream_adapter

Stream front-end for the quicksort core. Accepts 4-bit elements one at a time over a valid/ready handshake and packs them into a flat array. It then launches one sort run on the core, captures the core's sorted array when the core signals completion, and streams the result back out one element per handshake. The block wraps the quicksort core so upstream and downstream logic never handle the packed-array interface directly.

## Interface
- ARR_WIDTH, 4: elements per frame, each 4 bits wide. Legal range 2..16, bounded by the core's 4-bit index ports.
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- in_data  in  4  input element.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts an element this cycle.
- sort_array  out  ARR_WIDTH*4  packed frame to the core. Element k occupies bits [4k+3:4k].
- sort_enable  out  1  one-cycle start pulse to the core.
- sort_lo  out  4  constant 0.
- sort_hi  out  4  constant ARR_WIDTH-1.
- sort_valid  in  1  core completion flag (core's array_valid).
- sort_result  in  ARR_WIDTH*4  core's sorted array, same packing as sort_array.
- out_data  out  4  output element.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  marks the final element of a frame.
- sort_err  out  1  sticky watchdog error. Only active when the watchdog is compiled in (see Configuration).

## Operation
- States: LOAD, START, GUARD, WAIT, DRAIN. Reset enters LOAD.
- Reset values: in_ready=0 during reset, then 1 once in LOAD. sort_array=0, sort_enable=0, out_data=0, out_valid=0, out_last=0, sort_err=0. Element index idx=0.
- LOAD: in_ready=1.
  - On in_valid&&in_ready, write in_data to slot idx and increment idx.
  - Accepting slot ARR_WIDTH-1 clears idx to 0 and moves to START.
  - Elements are never dropped. in_valid without in_ready has no effect.
- START: sort_enable=1 for exactly one cycle. sort_array is held stable from this cycle until the next LOAD. Next state is GUARD.
- GUARD: one cycle in which sort_valid is ignored, so a stale completion flag from the previous run is not mistaken for this one. Next state is WAIT.
- WAIT: on the first cycle sort_valid=1, copy sort_result into the output buffer and go to DRAIN. Otherwise remain in WAIT.
- DRAIN: out_valid=1, out_data=buffer[idx], out_last=(idx==ARR_WIDTH-1).
  - On out_valid&&out_ready, increment idx.
  - When the last element is accepted, clear idx and go to LOAD.
  - While out_ready=0, out_data and out_last hold steady.
- in_ready=0 in every state except LOAD. out_valid=0 in every state except DRAIN.
- idx width is 4 bits. It is never incremented past ARR_WIDTH-1, so there is no wrap-around.
- Reset mid-operation, in any state: return to LOAD, idx=0, all outputs at reset values, partial frame discarded.

## Timing
- Last input accepted at cycle t: START (sort_enable=1) at t+1, GUARD at t+2, WAIT from t+3.
- sort_valid first sampled high at cycle u (u≥t+3): out_valid=1 with element 0 at u+1.
- With out_ready held at 1, one element per cycle. out_last is high at u+ARR_WIDTH. in_ready=1 at u+ARR_WIDTH+1.
- All outputs are registered or decoded directly from state/idx. No combinational path from in_valid or out_ready to any output.

## Configuration
- SORT_ADAPTER_TIMEOUT_EN defined:
  - An 8-bit watchdog clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches 255 with no sort_valid, sort_err is set (sticky until reset) and the output buffer is loaded with the unsorted sort_array.
  - The block then proceeds to DRAIN as normal.
- SORT_ADAPTER_TIMEOUT_EN undefined: no watchdog, sort_err tied to 0, and WAIT waits indefinitely.

## Test plan
- ARR_WIDTH=4, input 3,1,2,0 with in_valid continuous. Core model asserts sort_valid 10 cycles after sort_enable with result 0,1,2,3. Expect sort_array=16'h0213, one sort_enable pulse, then out stream 0,1,2,3 with out_last on the 3rd... strictly on element 3 (the fourth), and sort_err=0.
- Random gaps on in_valid and out_ready toggling 1,0,0,1 during DRAIN. Expect identical data, each element held while out_ready=0, and no duplicated or dropped elements.
- sort_valid held at 1 from the previous run through START and GUARD. Expect capture only on the first WAIT cycle (t+3), not before.
- Reset asserted after 2 of 4 elements, and separately mid-DRAIN. Expect all outputs 0 during reset, in_ready=1 afterwards, and the next frame 7,7,1,5 sorts to 1,5,7,7.
- With SORT_ADAPTER_TIMEOUT_EN defined, sort_valid never asserted. Expect sort_err=1 after 255 WAIT cycles, then unsorted input 3,1,2,0 streamed out. Without the macro, the block stays in WAIT and sort_err=0.

Source files
------------

// File: rtl/sort_stream_adapter.sv
// sort_stream_adapter: stream front-end for the quicksort core.
// Packs ARR_WIDTH 4-bit elements from a valid/ready stream into a flat frame,
// launches one sort run, captures the sorted frame on completion and streams
// it back out one element per handshake with out_last on the final element.
// Optional macro SORT_ADAPTER_TIMEOUT_EN adds a WAIT-state watchdog that sets
// a sticky sort_err and drains the unsorted frame if the core never answers.
module sort_stream_adapter #(
   parameter int unsigned ARR_WIDTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [3:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [ARR_WIDTH*4-1:0] sort_array,
   output logic                   sort_enable,
   output logic [3:0]             sort_lo,
   output logic [3:0]             sort_hi,
   input  logic                   sort_valid,
   input  logic [ARR_WIDTH*4-1:0] sort_result,
   output logic [3:0]             out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic                   sort_err
);

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_START,
      ST_GUARD,
      ST_WAIT,
      ST_DRAIN
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'(ARR_WIDTH - 1);

   state_t                 state_q, state_d;
   logic [3:0]             idx_q, idx_d;
   logic [ARR_WIDTH*4-1:0] array_q, array_d;
   logic [ARR_WIDTH*4-1:0] buf_q, buf_d;
   logic [3:0]             out_elem;
`ifdef SORT_ADAPTER_TIMEOUT_EN
   logic [7:0]             wd_q, wd_d;
   logic                   err_q, err_d;
`endif

   // Next-state, element index, frame and capture-buffer updates
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      array_d = array_q;
      buf_d   = buf_q;
`ifdef SORT_ADAPTER_TIMEOUT_EN
      wd_d    = wd_q;
      err_d   = err_q;
`endif
      case (state_q)
         ST_LOAD: begin
            if (in_valid) begin
               for (int unsigned k = 0; k < ARR_WIDTH; k++) begin
                  if (idx_q == 4'(k)) array_d[k*4 +: 4] = in_data;
               end
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = ST_START;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         ST_START: state_d = ST_GUARD;
         ST_GUARD: begin
            state_d = ST_WAIT;
`ifdef SORT_ADAPTER_TIMEOUT_EN
            wd_d    = '0;
`endif
         end
         ST_WAIT: begin
            if (sort_valid) begin
               buf_d   = sort_result;
               state_d = ST_DRAIN;
            end
`ifdef SORT_ADAPTER_TIMEOUT_EN
            // Counter value 254 marks the 255th WAIT cycle without completion
            else if (wd_q == 8'd254) begin
               buf_d   = array_q;
               err_d   = 1'b1;
               state_d = ST_DRAIN;
            end else begin
               wd_d = wd_q + 8'd1;
            end
`endif
         end
         ST_DRAIN: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = ST_LOAD;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_LOAD;
         idx_q   <= '0;
         array_q <= '0;
         buf_q   <= '0;
`ifdef SORT_ADAPTER_TIMEOUT_EN
         wd_q    <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         array_q <= array_d;
         buf_q   <= buf_d;
`ifdef SORT_ADAPTER_TIMEOUT_EN
         wd_q    <= wd_d;
         err_q   <= err_d;
`endif
      end
   end

   // Output decode from state and index only; forced to idle while reset is high
   always_comb begin
      out_elem = '0;
      for (int unsigned k = 0; k < ARR_WIDTH; k++) begin
         if (idx_q == 4'(k)) out_elem = buf_q[k*4 +: 4];
      end
      in_ready    = 1'b0;
      sort_enable = 1'b0;
      out_valid   = 1'b0;
      out_data    = '0;
      out_last    = 1'b0;
      if (!reset) begin
         case (state_q)
            ST_LOAD:  in_ready    = 1'b1;
            ST_START: sort_enable = 1'b1;
            ST_DRAIN: begin
               out_valid = 1'b1;
               out_data  = out_elem;
               out_last  = (idx_q == LAST_IDX);
            end
            default: ;
         endcase
      end
   end

   assign sort_array = array_q;
   assign sort_lo    = '0;
   assign sort_hi    = LAST_IDX;
`ifdef SORT_ADAPTER_TIMEOUT_EN
   assign sort_err   = err_q;
`else
   assign sort_err   = 1'b0;
`endif

endmodule
